clk_gen_multi: RTL

CLK_GEN_MULTI -- requirements
Module: clk_gen_multi

---
 rtl/clk_gen_pkg.sv | 19 +
 rtl/clk_gen_channel.sv | 152 +++++++++++++++
 rtl/clk_gen_multi.sv | 76 +++++++
 3 files changed

// File: rtl/clk_gen_pkg.sv
// Shared encodings for the multi-channel programmable clock generator.
package clk_gen_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_CONT  = 2'd1,
        MODE_BURST = 2'd2,
        MODE_STEP  = 2'd3
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_t;

    localparam int RST_DIV  = 2;
    localparam int RST_HIGH = 1;

endpackage

// File: rtl/clk_gen_channel.sv
// One clock-generator channel: holds its configuration and produces a
// continuous, burst or single-period clock with graceful stop.
module clk_gen_channel
    import clk_gen_pkg::*;
#(
    parameter int DIV_BITS = 16,
    parameter int CNT_BITS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_load,
    input  logic [1:0]          cfg_mode,
    input  logic [DIV_BITS-1:0] cfg_div,
    input  logic [DIV_BITS-1:0] cfg_high,
    input  logic [CNT_BITS-1:0] cfg_count,
    input  logic                start,
    input  logic                stop,
    output logic                clk_o,
    output logic                busy,
    output logic                done
);

    ch_state_t           state_reg, state_next;
    mode_t               mode_reg, mode_next, run_mode_reg, run_mode_next;
    logic [DIV_BITS-1:0] div_reg, div_next, high_reg, high_next;
    logic [CNT_BITS-1:0] count_reg, count_next;
    logic [DIV_BITS-1:0] run_period_reg, run_period_next, run_high_reg, run_high_next;
    logic [DIV_BITS-1:0] phase_reg, phase_next, phase_inc;
    logic [CNT_BITS-1:0] remaining_reg, remaining_next;
    logic                stop_pend_reg, stop_pend_next;
    logic                clk_o_reg, clk_o_next, done_reg, done_next;
    logic [DIV_BITS-1:0] eff_period, eff_period_m1, eff_high;
    logic                last_period;

    // Period/high are sanitised once at start so a running channel never
    // sees a degenerate (all-high or all-low) waveform.
    always_comb begin
        eff_period    = (div_reg < DIV_BITS'(2)) ? DIV_BITS'(2) : div_reg;
        eff_period_m1 = eff_period - DIV_BITS'(1);
        if (high_reg == '0)
            eff_high = DIV_BITS'(1);
        else if (high_reg > eff_period_m1)
            eff_high = eff_period_m1;
        else
            eff_high = high_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            mode_reg       <= MODE_OFF;
            div_reg        <= DIV_BITS'(RST_DIV);
            high_reg       <= DIV_BITS'(RST_HIGH);
            count_reg      <= '0;
            run_mode_reg   <= MODE_OFF;
            run_period_reg <= DIV_BITS'(RST_DIV);
            run_high_reg   <= DIV_BITS'(RST_HIGH);
            phase_reg      <= '0;
            remaining_reg  <= '0;
            stop_pend_reg  <= 1'b0;
            clk_o_reg      <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            mode_reg       <= mode_next;
            div_reg        <= div_next;
            high_reg       <= high_next;
            count_reg      <= count_next;
            run_mode_reg   <= run_mode_next;
            run_period_reg <= run_period_next;
            run_high_reg   <= run_high_next;
            phase_reg      <= phase_next;
            remaining_reg  <= remaining_next;
            stop_pend_reg  <= stop_pend_next;
            clk_o_reg      <= clk_o_next;
            done_reg       <= done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        mode_next       = mode_reg;
        div_next        = div_reg;
        high_next       = high_reg;
        count_next      = count_reg;
        run_mode_next   = run_mode_reg;
        run_period_next = run_period_reg;
        run_high_next   = run_high_reg;
        phase_next      = phase_reg;
        remaining_next  = remaining_reg;
        stop_pend_next  = stop_pend_reg;
        clk_o_next      = clk_o_reg;
        done_next       = 1'b0;
        phase_inc       = phase_reg + DIV_BITS'(1);
        last_period     = stop || stop_pend_reg ||
                          (run_mode_reg != MODE_CONT && remaining_reg == CNT_BITS'(1));

        if (cfg_load) begin
            mode_next  = mode_t'(cfg_mode);
            div_next   = cfg_div;
            high_next  = cfg_high;
            count_next = cfg_count;
        end

        case (state_reg)
            ST_IDLE: begin
                clk_o_next     = 1'b0;
                stop_pend_next = 1'b0;
                if (start && !stop && mode_reg != MODE_OFF) begin
                    if (mode_reg == MODE_BURST && count_reg == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next      = ST_RUN;
                        run_mode_next   = mode_reg;
                        run_period_next = eff_period;
                        run_high_next   = eff_high;
                        phase_next      = '0;
                        clk_o_next      = 1'b1;
                        remaining_next  = (mode_reg == MODE_BURST) ? count_reg : CNT_BITS'(1);
                    end
                end
            end
            ST_RUN: begin
                if (stop)
                    stop_pend_next = 1'b1;
                // Decisions to stop are only taken at a period boundary.
                if (phase_reg == run_period_reg - DIV_BITS'(1)) begin
                    if (last_period) begin
                        state_next     = ST_IDLE;
                        clk_o_next     = 1'b0;
                        done_next      = 1'b1;
                        stop_pend_next = 1'b0;
                    end else begin
                        phase_next = '0;
                        clk_o_next = 1'b1;
                        if (run_mode_reg != MODE_CONT)
                            remaining_next = remaining_reg - CNT_BITS'(1);
                    end
                end else begin
                    phase_next = phase_inc;
                    clk_o_next = (phase_inc < run_high_reg);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign clk_o = clk_o_reg;
    assign busy  = (state_reg == ST_RUN);
    assign done  = done_reg;

endmodule

// File: rtl/clk_gen_multi.sv
// Multi-channel clock generator: configuration write decode and error
// reporting around NCH independent channels.
module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int DIV_BITS = 16,
    parameter int CNT_BITS = 32,
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [DIV_BITS-1:0] cfg_div,
    input  logic [DIV_BITS-1:0] cfg_high,
    input  logic [CNT_BITS-1:0] cfg_count,
    input  logic [NCH-1:0]      start,
    input  logic [NCH-1:0]      stop,
    output logic [NCH-1:0]      clk_o,
    output logic [NCH-1:0]      busy,
    output logic [NCH-1:0]      done,
    output logic                cfg_err
);

    logic [NCH-1:0] cfg_load;
    logic           ch_valid, target_busy, cfg_accept;
    logic           cfg_err_reg, cfg_err_next;

    // Explicit search avoids an out-of-range index when NCH is not a power of two.
    always_comb begin
        target_busy = 1'b0;
        for (int i = 0; i < NCH; i++)
            if (cfg_ch == CH_W'(i))
                target_busy = busy[i];
    end

    assign ch_valid     = (int'(cfg_ch) < NCH);
    assign cfg_accept   = cfg_we && ch_valid && !target_busy;
    assign cfg_err_next = cfg_we && !cfg_accept;

    always_ff @(posedge clk) begin
        if (reset)
            cfg_err_reg <= 1'b0;
        else
            cfg_err_reg <= cfg_err_next;
    end

    assign cfg_err = cfg_err_reg;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign cfg_load[gi] = cfg_accept && (cfg_ch == CH_W'(gi));

            clk_gen_channel #(
                .DIV_BITS (DIV_BITS),
                .CNT_BITS (CNT_BITS)
            ) u_ch (
                .clk       (clk),
                .reset     (reset),
                .cfg_load  (cfg_load[gi]),
                .cfg_mode  (cfg_mode),
                .cfg_div   (cfg_div),
                .cfg_high  (cfg_high),
                .cfg_count (cfg_count),
                .start     (start[gi]),
                .stop      (stop[gi]),
                .clk_o     (clk_o[gi]),
                .busy      (busy[gi]),
                .done      (done[gi])
            );
        end
    endgenerate

endmodule
